song_sequencer: RTL and testbench



---
 rtl/song_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_song_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Melody player: walks a two-song ROM entry by entry and drives the buzzer's
// note/octave inputs, with beat timing, inter-note gaps, pause, stop and loop.
module song_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic       song_sel,
  output logic [3:0] note,
  output logic [1:0] octave,
  output logic       playing,
  output logic       done,
  output logic [4:0] index
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  // Entry layout: {dur[2:0], octave[1:0], note[3:0]}; dur == 0 ends the song.
  function automatic logic [8:0] rom_entry(input logic song, input logic [4:0] idx);
    logic [8:0] e;
    case ({song, idx})
      {1'b0, 5'd0}: e = {3'd1, 2'b00, 4'd1};
      {1'b0, 5'd1}: e = {3'd1, 2'b00, 4'd1};
      {1'b0, 5'd2}: e = {3'd1, 2'b00, 4'd5};
      {1'b0, 5'd3}: e = {3'd1, 2'b00, 4'd5};
      {1'b0, 5'd4}: e = {3'd1, 2'b00, 4'd6};
      {1'b0, 5'd5}: e = {3'd1, 2'b00, 4'd6};
      {1'b0, 5'd6}: e = {3'd2, 2'b00, 4'd5};
      {1'b1, 5'd0}: e = {3'd1, 2'b00, 4'd1};
      {1'b1, 5'd1}: e = {3'd1, 2'b00, 4'd2};
      {1'b1, 5'd2}: e = {3'd1, 2'b00, 4'd3};
      {1'b1, 5'd3}: e = {3'd1, 2'b00, 4'd4};
      {1'b1, 5'd4}: e = {3'd1, 2'b00, 4'd5};
      {1'b1, 5'd5}: e = {3'd1, 2'b00, 4'd6};
      {1'b1, 5'd6}: e = {3'd1, 2'b00, 4'd7};
      {1'b1, 5'd7}: e = {3'd2, 2'b10, 4'd1};
      default:      e = 9'd0;
    endcase
    return e;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  index_q, index_d;
  logic        song_q, song_d;
  logic [3:0]  note_q, note_d;
  logic [1:0]  octave_q, octave_d;
  logic        playing_q, playing_d;
  logic        done_q, done_d;

  logic [8:0]  cur_entry, nxt_entry, first_new, first_cur;
  logic [31:0] play_len;
  logic        song_end;

  assign cur_entry = rom_entry(song_q, index_q);
  assign nxt_entry = rom_entry(song_q, index_q + 5'd1);
  assign first_new = rom_entry(song_sel, 5'd0);
  assign first_cur = rom_entry(song_q, 5'd0);
  assign play_len  = {29'd0, cur_entry[8:6]} * BEAT_CYCLES - GAP_CYCLES;
  assign song_end  = (nxt_entry[8:6] == 3'd0) || (index_q == 5'd31);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    index_d   = index_q;
    song_d    = song_q;
    note_d    = note_q;
    octave_d  = octave_q;
    playing_d = playing_q;
    done_d    = done_q;

    if (stop) begin
      state_d   = S_IDLE;
      cnt_d     = 32'd0;
      index_d   = 5'd0;
      song_d    = 1'b0;
      note_d    = 4'd0;
      octave_d  = 2'b00;
      playing_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            song_d  = song_sel;
            index_d = 5'd0;
            cnt_d   = 32'd0;
            if (first_new[8:6] == 3'd0) begin
              state_d   = S_DONE;
              note_d    = 4'd0;
              octave_d  = 2'b00;
              playing_d = 1'b0;
              done_d    = 1'b1;
            end else begin
              state_d   = S_PLAY;
              note_d    = first_new[3:0];
              octave_d  = first_new[5:4];
              playing_d = 1'b1;
              done_d    = 1'b0;
            end
          end
        end
        S_PLAY: begin
          if (pause) begin
            note_d = 4'd0;
          end else if (cnt_q == play_len - 32'd1) begin
            state_d = S_GAP;
            cnt_d   = 32'd0;
            note_d  = 4'd0;
          end else begin
            cnt_d    = cnt_q + 32'd1;
            note_d   = cur_entry[3:0];
            octave_d = cur_entry[5:4];
          end
        end
        S_GAP: begin
          if (pause) begin
            note_d = 4'd0;
          end else if (cnt_q == GAP_CYCLES - 32'd1) begin
            cnt_d = 32'd0;
            if (!song_end) begin
              index_d  = index_q + 5'd1;
              state_d  = S_PLAY;
              note_d   = nxt_entry[3:0];
              octave_d = nxt_entry[5:4];
            end else if (loop_en && first_cur[8:6] != 3'd0) begin
              index_d  = 5'd0;
              state_d  = S_PLAY;
              note_d   = first_cur[3:0];
              octave_d = first_cur[5:4];
            end else begin
              // index keeps pointing at the last entry that was played
              state_d   = S_DONE;
              note_d    = 4'd0;
              octave_d  = 2'b00;
              playing_d = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      index_q   <= 5'd0;
      song_q    <= 1'b0;
      note_q    <= 4'd0;
      octave_q  <= 2'b00;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      index_q   <= index_d;
      song_q    <= song_d;
      note_q    <= note_d;
      octave_q  <= octave_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign note    = note_q;
  assign octave  = octave_q;
  assign playing = playing_q;
  assign done    = done_q;
  assign index   = index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random control traffic,
// all compared against a countdown-based melody model.
module tb_song_sequencer;

  localparam int B = 10;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, pause, loop_en, song_sel;
  logic [3:0] note;
  logic [1:0] octave;
  logic       playing, done;
  logic [4:0] index;

  int checks = 0;
  int errors = 0;

  song_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .song_sel(song_sel), .note(note), .octave(octave),
    .playing(playing), .done(done), .index(index)
  );

  always #5 clk = ~clk;

  // Song table written straight from the melody listing.
  int s_note [2][32];
  int s_oct  [2][32];
  int s_dur  [2][32];

  // Model: phase 0 idle, 1 play, 2 gap, 3 done; rem = cycles left in phase.
  int m_ph, m_idx, m_song, m_rem, m_note, m_oct;

  task automatic init_rom();
    int n0[7] = '{1, 1, 5, 5, 6, 6, 5};
    int n1[8] = '{1, 2, 3, 4, 5, 6, 7, 1};
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++) begin
        s_note[s][i] = 0; s_oct[s][i] = 0; s_dur[s][i] = 0;
      end
    for (int i = 0; i < 7; i++) begin
      s_note[0][i] = n0[i]; s_dur[0][i] = (i == 6) ? 2 : 1;
    end
    for (int i = 0; i < 8; i++) begin
      s_note[1][i] = n1[i]; s_dur[1][i] = (i == 7) ? 2 : 1;
    end
    s_oct[1][7] = 2;
  endtask

  task automatic model_reset();
    m_ph = 0; m_idx = 0; m_song = 0; m_rem = 0; m_note = 0; m_oct = 0;
  endtask

  task automatic model_enter_play(input int idx);
    m_idx  = idx;
    m_ph   = 1;
    m_rem  = s_dur[m_song][idx] * B - G;
    m_note = s_note[m_song][idx];
    m_oct  = s_oct[m_song][idx];
  endtask

  task automatic model_step();
    if (stop) begin
      model_reset();
    end else if ((m_ph == 0 || m_ph == 3) && start) begin
      m_song = int'(song_sel);
      if (s_dur[m_song][0] == 0) begin
        m_idx = 0; m_ph = 3; m_note = 0; m_oct = 0;
      end else begin
        model_enter_play(0);
      end
    end else if (m_ph == 1 || m_ph == 2) begin
      if (pause) begin
        m_note = 0;
      end else begin
        m_rem--;
        if (m_ph == 1) begin
          if (m_rem == 0) begin
            m_ph = 2; m_rem = G; m_note = 0;
          end else begin
            m_note = s_note[m_song][m_idx];
            m_oct  = s_oct[m_song][m_idx];
          end
        end else if (m_rem == 0) begin
          if (m_idx == 31 || s_dur[m_song][m_idx + 1] == 0) begin
            if (loop_en) model_enter_play(0);
            else begin
              m_ph = 3; m_note = 0; m_oct = 0;
            end
          end else begin
            model_enter_play(m_idx + 1);
          end
        end
      end
    end
  endtask

  function automatic logic [12:0] dut_vec();
    return {note, octave, index, playing, done};
  endfunction

  function automatic logic [12:0] mdl_vec();
    return {4'(m_note), 2'(m_oct), 5'(m_idx), 1'(m_ph == 1 || m_ph == 2), 1'(m_ph == 3)};
  endfunction

  // One clock: model and DUT see the same inputs at the edge; sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; stop = 0; pause = 0; loop_en = 0; song_sel = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic sel);
    song_sel = sel; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", dut_vec());
    end
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL idle_pause: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_first_note();
    int ones = 0;
    do_reset();
    pulse_start(1'b0);
    checks++;
    if ({note, octave, index, playing} !== {4'd1, 2'b00, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL first_note: got n=%0d o=%0d i=%0d p=%0d expected n=1 o=0 i=0 p=1",
               note, octave, index, playing);
    end
    ones = 1;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (note == 4'd1 && index == 5'd0) ones++;
    end
    checks++;
    if (ones !== 8) begin
      errors++;
      $display("FAIL first_note_len: got %0d cycles expected 8", ones);
    end
    tick();
    checks++;
    if (note !== 4'd1 || index !== 5'd1) begin
      errors++;
      $display("FAIL second_entry: got n=%0d i=%0d expected n=1 i=1", note, index);
    end
  endtask

  task automatic test_song0_full();
    int seq[$];
    int exp_seq[7] = '{1, 1, 5, 5, 6, 6, 5};
    int last_len = 0;
    logic [3:0] prev = 4'd0;
    do_reset();
    pulse_start(1'b0);
    seq.push_back(int'(note));
    prev = note;
    last_len = 0;
    for (int c = 1; c < 80; c++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL song0_cycle%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
      if (note != 4'd0 && prev == 4'd0) seq.push_back(int'(note));
      if (index == 5'd6 && note != 4'd0) last_len++;
      prev = note;
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL song0_early_done: got %0d expected 0", done);
    end
    tick();
    checks++;
    if ({done, note, index} !== {1'b1, 4'd0, 5'd6}) begin
      errors++;
      $display("FAIL song0_done: got d=%0d n=%0d i=%0d expected d=1 n=0 i=6", done, note, index);
    end
    checks++;
    if (last_len !== 18) begin
      errors++;
      $display("FAIL song0_last_len: got %0d expected 18", last_len);
    end
    checks++;
    if (seq.size() != 7 || seq[0] != exp_seq[0] || seq[2] != exp_seq[2] ||
        seq[4] != exp_seq[4] || seq[6] != exp_seq[6]) begin
      errors++;
      $display("FAIL song0_sequence: got %0d notes expected 1,1,5,5,6,6,5", seq.size());
    end
  endtask

  task automatic test_song1_loop();
    int hi_len = 0;
    logic seen7 = 1'b0, any_done = 1'b0, wrap_ok = 1'b0, wrapped = 1'b0;
    do_reset();
    loop_en = 1'b1;
    pulse_start(1'b1);
    for (int c = 1; c < 100; c++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL song1_cycle%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
      if (index == 5'd7) seen7 = 1'b1;
      if (index == 5'd7 && note == 4'd1 && octave == 2'b10) hi_len++;
      if (seen7 && !wrapped && index == 5'd0) begin
        wrapped = 1'b1;
        wrap_ok = (note == 4'd1 && octave == 2'b00);
      end
      if (done) any_done = 1'b1;
    end
    loop_en = 1'b0;
    checks++;
    if (hi_len !== 18) begin
      errors++;
      $display("FAIL song1_entry7_len: got %0d expected 18", hi_len);
    end
    checks++;
    if (!(wrapped && wrap_ok) || any_done) begin
      errors++;
      $display("FAIL song1_loop: got wrap=%0d ok=%0d done=%0d expected 1 1 0", wrapped, wrap_ok, any_done);
    end
  endtask

  task automatic test_pause();
    int after = 0;
    do_reset();
    pulse_start(1'b0);
    repeat (4) tick();
    pause = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (note !== 4'd0 || index !== 5'd0 || playing !== 1'b1) begin
        errors++;
        $display("FAIL pause_hold%0d: got n=%0d i=%0d p=%0d expected n=0 i=0 p=1", c, note, index, playing);
      end
    end
    pause = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (note == 4'd1) after++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL pause_resume%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (after !== 3 || note !== 4'd0) begin
      errors++;
      $display("FAIL pause_remaining: got %0d cycles n=%0d expected 3 cycles then n=0", after, note);
    end
  endtask

  task automatic test_back_to_back();
    int ones = 1;
    do_reset();
    pulse_start(1'b0);
    repeat (24) tick();
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    checks++;
    if ({note, index, playing, done} !== {4'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stop_start: got n=%0d i=%0d p=%0d d=%0d expected all 0", note, index, playing, done);
    end
    pulse_start(1'b0);
    for (int c = 1; c < 12; c++) begin
      start = (c == 3 || c == 7);
      song_sel = 1'b1;
      tick();
      start = 1'b0;
      if (c < 10 && note == 4'd1 && index == 5'd0) ones++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL start_ignored%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (ones !== 8 || index !== 5'd1 || note !== 4'd1) begin
      errors++;
      $display("FAIL start_ignored_timing: got %0d cycles i=%0d expected 8 cycles i=1", ones, index);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_start(1'b0);
    repeat (8) tick();
    checks++;
    if (note !== 4'd0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL gap_before_reset: got n=%0d p=%0d expected n=0 p=1", note, playing);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    #1 rst_n = 1'b1;
    pulse_start(1'b1);
    checks++;
    if ({note, index, playing} !== {4'd1, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_after_reset: got n=%0d i=%0d p=%0d expected n=1 i=0 p=1", note, index, playing);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      start    = ($urandom_range(0, 39) == 0);
      stop     = ($urandom_range(0, 399) == 0);
      song_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL random%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    start = 0; stop = 0; pause = 0; loop_en = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    init_rom();
    model_reset();
    test_reset();
    test_first_note();
    test_song0_full();
    test_song1_loop();
    test_pause();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
